// File: rtl/conv2_pkg.sv
// conv2_pkg: shared conv2 state encoding and default feature-map geometry
package conv2_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, NEXT, DONE} state_t;
    localparam int WIDTH_DEF     = 12;
    localparam int HEIGHT_DEF    = 12;
    localparam int CHANNELS_DEF  = 3;
    localparam int FLUSH_PIX_DEF = 12;
    localparam int PIX_PER_CH    = WIDTH_DEF * HEIGHT_DEF;
endpackage

// File: rtl/conv2_addr_gen.sv
// conv2_addr_gen: channel/pixel counters and pool-RAM address for the conv2 sequencer
module conv2_addr_gen
    import conv2_pkg::*;
#(
    parameter int PIX       = PIX_PER_CH,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ch_clr,
    input  logic                 pix_clr,
    input  logic                 ch_inc,
    input  logic                 en,
    output logic [1:0]           ch,
    output logic [ADDR_BITS-1:0] pix,
    output logic [ADDR_BITS-1:0] mem_addr
);
    // channel index: cleared on a fresh start, advanced between channels
    always_ff @(posedge clk) begin
        if (rst || ch_clr) ch <= '0;
        else if (ch_inc)   ch <= ch + 1'b1;
    end
    // pixel index within the channel: advances once per issued read
    always_ff @(posedge clk) begin
        if (rst || pix_clr) pix <= '0;
        else if (en)        pix <= pix + 1'b1;
    end
    assign mem_addr = ADDR_BITS'(ch) * ADDR_BITS'(PIX) + pix;
endmodule

// File: rtl/conv2_ctrl.sv
// conv2_ctrl: streams pooled channels from pool RAM into the conv2 window buffer
module conv2_ctrl
    import conv2_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int HEIGHT    = HEIGHT_DEF,
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int DATA_BITS = 14,
    parameter int ADDR_BITS = 10,
    parameter int FLUSH_PIX = FLUSH_PIX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 buf_clear,
    output logic                 buf_valid_in,
    output logic [DATA_BITS-1:0] buf_data_in,
    input  logic                 buf_valid_out,
    output logic                 win_valid,
    output logic [1:0]           win_ch,
    output logic                 win_last_ch
);
    localparam int PIX     = WIDTH * HEIGHT;
    localparam int FC_BITS = $clog2(FLUSH_PIX + 1);

    state_t               state, state_nx;
    logic [1:0]           ch;
    logic [ADDR_BITS-1:0] pix;
    logic [FC_BITS-1:0]   flush_cnt;
    logic                 flush_issue;
    logic                 rd_q;
    logic                 last_ch;

    assign last_ch = ch == 2'(CHANNELS - 1);

    conv2_addr_gen #(.PIX(PIX), .ADDR_BITS(ADDR_BITS)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .ch_clr   (state == IDLE && start),
        .pix_clr  (state == CLEAR),
        .ch_inc   (state == NEXT && !last_ch),
        .en       (mem_rd_en),
        .ch       (ch),
        .pix      (pix),
        .mem_addr (mem_addr)
    );

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    // next state and state-decoded strobes; hold only gates FETCH reads and flush issue
    always_comb begin
        state_nx    = state;
        busy        = state == CLEAR || state == FETCH || state == DRAIN || state == NEXT;
        done        = state == DONE;
        buf_clear   = state == CLEAR;
        mem_rd_en   = state == FETCH && !hold;
        flush_issue = state == DRAIN && !hold && flush_cnt < FC_BITS'(FLUSH_PIX);
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = FETCH;
            FETCH:   state_nx = (!hold && pix == ADDR_BITS'(PIX - 1)) ? DRAIN : FETCH;
            DRAIN:   state_nx = (flush_cnt == FC_BITS'(FLUSH_PIX)) ? NEXT : DRAIN;
            NEXT:    state_nx = last_ch ? DONE : CLEAR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // flush pixels issued so far in this DRAIN; the extra terminal count lets the last one land
    always_ff @(posedge clk) begin
        if (rst || state != DRAIN) flush_cnt <= '0;
        else if (flush_issue)      flush_cnt <= flush_cnt + 1'b1;
    end

    // delivery stage lines the strobe up with the RAM's registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= 1'b0;
            buf_valid_in <= 1'b0;
            win_ch       <= '0;
        end else begin
            rd_q         <= mem_rd_en;
            buf_valid_in <= mem_rd_en | flush_issue;
            win_ch       <= ch;
        end
    end

    assign buf_data_in = rd_q ? mem_rd_data : '0;
    assign win_valid   = buf_valid_out & busy;
    assign win_last_ch = win_ch == 2'(CHANNELS - 1);
endmodule

// File: tb/tb_conv2_ctrl.sv
// tb_conv2_ctrl: self-checking bench for conv2_ctrl against a slot-schedule reference model
module tb_conv2_ctrl;
    localparam int DB = 14;
    localparam int AB = 10;
    localparam int NPIX = 144;
    localparam int NCH = 3;
    localparam int NFL = 12;
    localparam int K_CLR = 0, K_FET = 1, K_FLU = 2, K_WAIT = 3, K_NEXT = 4, K_DONE = 5;

    typedef struct {int kind; bit sens; int addr; int ch;} slot_t;
    typedef struct {int cyc; int clr; int dn; int bsy; int rd; int addr; int bvi; int bd;} vec_t;

    logic          clk = 1'b0;
    logic          rst, start, hold, buf_valid_out;
    logic          busy, done, mem_rd_en, buf_clear, buf_valid_in, win_valid, win_last_ch;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_rd_data, buf_data_in;
    logic [1:0]    win_ch;

    int     errs = 0;
    int     checks = 0;
    int     cyc = -1;
    slot_t  q[$];
    vec_t   tbl[$];

    conv2_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .buf_clear(buf_clear), .buf_valid_in(buf_valid_in), .buf_data_in(buf_data_in),
        .buf_valid_out(buf_valid_out), .win_valid(win_valid), .win_ch(win_ch),
        .win_last_ch(win_last_ch)
    );

    always #5 clk = ~clk;

    // pool RAM returns its own address one cycle after the read strobe
    always @(posedge clk) mem_rd_data <= mem_rd_en ? DB'(mem_addr) : DB'(14'h2aaa);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic build();
        for (int c = 0; c < NCH; c++) begin
            q.push_back('{K_CLR, 1'b0, 0, c});
            for (int p = 0; p < NPIX; p++) q.push_back('{K_FET, 1'b1, c * NPIX + p, c});
            for (int f = 0; f < NFL; f++) q.push_back('{K_FLU, 1'b1, 0, c});
            q.push_back('{K_WAIT, 1'b0, 0, c});
            q.push_back('{K_NEXT, 1'b0, 0, c});
        end
        q.push_back('{K_DONE, 1'b0, 0, NCH - 1});
    endtask

    // modes: 0 plain with stray starts, 1 hold burst, 2 mid-run reset, 3 random hold, 4 plain restart
    task automatic run(input int mode, input int ncyc);
        slot_t cur;
        bit    act, pact, pv, rd_e, busy_e;
        int    pd, pch, ndone, done_at, bad;
        int    ga[$];
        int    gd[$];
        q.delete();
        pact = 0; pv = 0; pd = 0; pch = 0; ndone = 0; done_at = -1;
        for (int t = 0; t < ncyc; t++) begin
            cyc = t;
            start = (t == 0) || (mode == 0 && (t == 10 || t == 478));
            hold = (mode == 1 && t >= 211 && t <= 215) || (mode == 3 && $urandom_range(0, 9) < 3);
            rst = mode == 2 && t == 200;
            buf_valid_out = (mode == 0 && t == 500) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            act = q.size() > 0;
            cur = act ? q[0] : '{-1, 1'b0, 0, 0};
            busy_e = act && cur.kind != K_DONE;
            rd_e = act && cur.kind == K_FET && !hold;
            chk("busy", busy, busy_e);
            chk("buf_clear", buf_clear, act && cur.kind == K_CLR);
            chk("done", done, act && cur.kind == K_DONE);
            chk("mem_rd_en", mem_rd_en, rd_e);
            if (rd_e) chk("mem_addr", mem_addr, cur.addr);
            chk("buf_valid_in", buf_valid_in, pv);
            chk("buf_data_in", buf_data_in, pv ? pd : 0);
            chk("win_valid", win_valid, buf_valid_out && busy_e);
            if (pact) begin
                chk("win_ch", win_ch, pch);
                chk("win_last_ch", win_last_ch, pch == NCH - 1);
            end
            if (mem_rd_en) ga.push_back(int'(mem_addr));
            if (buf_valid_in) gd.push_back(int'(buf_data_in));
            if (done) begin ndone++; done_at = t; end
            if (mode == 0) foreach (tbl[i]) if (tbl[i].cyc == t) begin
                chk("tbl_clr", buf_clear, tbl[i].clr);
                chk("tbl_done", done, tbl[i].dn);
                chk("tbl_busy", busy, tbl[i].bsy);
                chk("tbl_rd", mem_rd_en, tbl[i].rd);
                if (tbl[i].addr >= 0) chk("tbl_addr", mem_addr, tbl[i].addr);
                chk("tbl_bvi", buf_valid_in, tbl[i].bvi);
                chk("tbl_bdata", buf_data_in, tbl[i].bd);
            end
            if (mode == 0 && t == 400) begin
                chk("ch2_win_ch", win_ch, 2);
                chk("ch2_last", win_last_ch, 1);
            end
            if (mode == 0 && t == 500) chk("idle_win_valid", win_valid, 0);
            if (mode == 1 && t == 211) begin
                chk("inflight_vld", buf_valid_in, 1);
                chk("inflight_data", buf_data_in, NPIX + 49);
            end
            if (mode == 1 && t == 215) chk("hold_rd", mem_rd_en, 0);
            if (mode == 1 && t == 216) begin
                chk("resume_rd", mem_rd_en, 1);
                chk("resume_addr", mem_addr, NPIX + 50);
            end
            if (mode == 2 && t == 201) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rd", mem_rd_en, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_clr", buf_clear, 0);
                chk("rst_bvi", buf_valid_in, 0);
                chk("rst_bdata", buf_data_in, 0);
                chk("rst_win_ch", win_ch, 0);
                chk("rst_last", win_last_ch, 0);
            end
            pv = rd_e || (act && cur.kind == K_FLU && !hold);
            pd = rd_e ? cur.addr : 0;
            pact = act;
            pch = cur.ch;
            if (act && !(cur.sens && hold)) void'(q.pop_front());
            else if (!act && start) build();
            if (rst) begin
                q.delete();
                pv = 0;
                pact = 0;
            end
            @(posedge clk);
            #1;
        end
        start = 0; hold = 0; rst = 0;
        if (mode != 2) begin
            chk("addr_count", ga.size(), NCH * NPIX);
            bad = -1;
            foreach (ga[i]) if (bad < 0 && ga[i] != i) bad = i;
            chk("addr_stream_bad_idx", bad, -1);
            chk("data_count", gd.size(), NCH * (NPIX + NFL));
            bad = -1;
            foreach (gd[i]) begin
                int r;
                r = i % (NPIX + NFL);
                if (bad < 0 && gd[i] != (r < NPIX ? (i / (NPIX + NFL)) * NPIX + r : 0)) bad = i;
            end
            chk("data_stream_bad_idx", bad, -1);
            chk("done_pulses", ndone, 1);
            if (mode == 0 || mode == 4) chk("done_cycle", done_at, 478);
            if (mode == 1) chk("done_cycle_hold", done_at, 483);
        end
    endtask

    initial begin
        tbl = '{
            '{0, 0, 0, 0, 0, 0, 0, 0},
            '{1, 1, 0, 1, 0, -1, 0, 0},
            '{2, 0, 0, 1, 1, 0, 0, 0},
            '{3, 0, 0, 1, 1, 1, 1, 0},
            '{145, 0, 0, 1, 1, 143, 1, 142},
            '{146, 0, 0, 1, 0, -1, 1, 143},
            '{147, 0, 0, 1, 0, -1, 1, 0},
            '{158, 0, 0, 1, 0, -1, 1, 0},
            '{159, 0, 0, 1, 0, -1, 0, 0},
            '{160, 1, 0, 1, 0, -1, 0, 0},
            '{161, 0, 0, 1, 1, 144, 0, 0},
            '{319, 1, 0, 1, 0, -1, 0, 0},
            '{320, 0, 0, 1, 1, 288, 0, 0},
            '{463, 0, 0, 1, 1, 431, 1, 430},
            '{464, 0, 0, 1, 0, -1, 1, 431},
            '{477, 0, 0, 1, 0, -1, 0, 0},
            '{478, 0, 1, 0, 0, -1, 0, 0},
            '{479, 0, 0, 0, 0, -1, 0, 0}
        };
        rst = 1; start = 0; hold = 0; buf_valid_out = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd", mem_rd_en, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_clr", buf_clear, 0);
        chk("reset_bvi", buf_valid_in, 0);
        chk("reset_bdata", buf_data_in, 0);
        chk("reset_win_valid", win_valid, 0);
        chk("reset_win_ch", win_ch, 0);
        chk("reset_last", win_last_ch, 0);
        rst = 0;
        @(posedge clk);
        #1;
        run(0, 510);
        run(1, 490);
        run(2, 202);
        run(4, 482);
        run(3, 1500);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/conv2_ctrl.md
# conv2_ctrl

Sequencer for the conv2 stage's 5x5 sliding-window buffer. It walks CHANNELS pooled feature maps (WIDTH x HEIGHT each) out of the pool-output memory and streams them pixel-by-pixel into the window buffer, clearing the buffer between channels. It then injects flush pixels so the last window row is emitted, and tags every emitted window with its channel index for the downstream multiply-accumulate. The block sits between the pool-output RAM and the window buffer, under a single start/done handshake from the top-level layer sequencer.

## Interface
- WIDTH, 12: feature-map width, in pixels.
- HEIGHT, 12: feature-map height, in pixels.
- CHANNELS, 3: number of input channels sequenced per start.
- DATA_BITS, 14: pixel width.
- ADDR_BITS, 10: memory address width; must hold CHANNELS*WIDTH*HEIGHT.
- FLUSH_PIX, 12 (=WIDTH): zero pixels injected after each channel.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- hold  in  1  downstream back-pressure; freezes pixel issue.
- busy  out  1  high from CLEAR through NEXT.
- done  out  1  one-cycle pulse after the last channel.
- mem_rd_en  out  1  pool-RAM read strobe.
- mem_addr  out  ADDR_BITS  pool-RAM address, ch*WIDTH*HEIGHT + pix.
- mem_rd_data  in  DATA_BITS  read data, valid 1 cycle after mem_rd_en.
- buf_clear  out  1  window-buffer clear; the top level drives the buffer reset as rst | buf_clear.
- buf_valid_in  out  1  pixel strobe to the window buffer.
- buf_data_in  out  DATA_BITS  pixel to the window buffer.
- buf_valid_out  in  1  window-valid from the window buffer.
- win_valid  out  1  buf_valid_out qualified by busy.
- win_ch  out  2  channel index of the current window.
- win_last_ch  out  1  high while win_ch == CHANNELS-1.

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, NEXT, DONE.
- IDLE: start=1 moves to CLEAR and sets ch=0.
- CLEAR: lasts 1 cycle; buf_clear=1, pix=0; then FETCH.
- FETCH: each cycle with hold=0, drive mem_rd_en=1 and mem_addr=ch*WIDTH*HEIGHT+pix, then pix++.
  - With hold=1: mem_rd_en=0 and pix holds.
  - After pix==WIDTH*HEIGHT-1 is issued, go to DRAIN.
- Delivery: buf_valid_in and buf_data_in are registered copies of the previous cycle's mem_rd_en and mem_rd_data.
  - A read already in flight when hold rises is still delivered.
- DRAIN: first cycle delivers the last fetched pixel.
  - Then FLUSH_PIX cycles inject buf_valid_in=1 with buf_data_in=0; flush_cnt advances only when hold=0.
  - After the final flush pixel, go to NEXT.
- NEXT: lasts 1 cycle. If ch==CHANNELS-1 go to DONE; otherwise ch++ and go to CLEAR.
- DONE: lasts 1 cycle; done=1, busy=0; then IDLE. start in DONE is ignored.
- win_valid = buf_valid_out & busy. win_ch = ch, registered so it stays aligned with buf_valid_out.
- Arithmetic: mem_addr is ch*(WIDTH*HEIGHT) + pix at ADDR_BITS, computed from constants with no overflow for the legal parameter range.

## Timing
- Reset values: every output is 0; state=IDLE; ch=pix=flush_cnt=0.
- Reset mid-operation: state goes to IDLE on the next edge and all outputs are 0. The in-flight read is discarded and buf_valid_in is not asserted.
- Cycle numbering below is with hold held low:
  - start in cycle 0.
  - CLEAR in cycle 1.
  - mem_rd_en in cycles 2..145.
  - Real pixels on buf_valid_in in cycles 3..146.
  - Flush pixels in cycles 147..158.
  - NEXT in cycle 159.
  - Each channel takes 159 cycles. Channel c's CLEAR is at 159c+1 and its NEXT at 159(c+1).
  - With CHANNELS=3, done is high in cycle 478 only.
- Each cycle of hold=1 during FETCH or flush extends the schedule by exactly 1 cycle.
- hold is ignored in CLEAR, NEXT, DONE and IDLE.
- start while busy has no effect.

## Structure
- conv2_pkg holds:
  - the state enum;
  - PIX_PER_CH = WIDTH*HEIGHT;
  - the default values of WIDTH, HEIGHT, CHANNELS and FLUSH_PIX, shared with the window buffer and conv2 core.
- One sub-module, conv2_addr_gen: the pix/ch counters and mem_addr computation, with enable = FETCH & ~hold.
- The FSM, delivery registers and flush counter stay in conv2_ctrl.

## Test plan
- Reset then single start with hold=0:
  - mem_addr runs 0..431 in 3 contiguous bursts of 144;
  - buf_clear is high at cycles 1, 160 and 319;
  - done is high only at cycle 478.
- Memory returns the address as data:
  - buf_data_in shows 0..143, then 12 zeros, per channel;
  - buf_valid_in is high for 156 cycles per channel.
- hold=1 for 5 cycles at pix=50 of channel 1:
  - in-flight pixel 49 is still delivered;
  - addr 50 is issued after the hold drops;
  - done moves to cycle 483.
- rst pulsed at cycle 200 (mid-FETCH, channel 1):
  - all outputs are 0 at cycle 201;
  - a new start restarts cleanly from addr 0.
- start re-asserted at cycles 10 and 478:
  - no effect;
  - exactly one done pulse.
- buf_valid_out forced high at cycle 500 (idle): win_valid stays 0. During channel 2, win_ch=2 and win_last_ch=1.
